// File: rtl/instr_opcode_decoder.sv
// instr_opcode_decoder
//
// Fetches one 32-bit instruction word at a time from instruction memory over a
// req/ack handshake, keeps the fetch address (PC), and decodes the 6-bit
// opcode into the one-hot operation-signal vector consumed by the microprogram
// start-address mapper. The decoded result is held under a valid/ready
// handshake until the control unit accepts it.
//
// Parameters:
//   RESET_PC   PC value loaded at reset
//   PC_STEP    PC increment per fetched instruction, in bytes
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   mem_addr   fetch address (always the PC)
//   mem_req    fetch request
//   mem_ack    memory returns mem_rdata this cycle
//   mem_rdata  instruction word, valid with mem_ack
//   pc_load    redirect request from the control unit (call/ret/jump)
//   pc_value   redirect target
//   signals    registered one-hot operation vector
//   operand    registered instruction bits [25:0]
//   illegal    registered flag: opcode not in the decode table
//   dec_valid  signals/operand/illegal are valid
//   dec_ready  control unit accepts the decoded instruction

module instr_opcode_decoder #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        pc_load,
    input  logic [31:0] pc_value,
    output logic [31:0] signals,
    output logic [25:0] operand,
    output logic        illegal,
    output logic        dec_valid,
    input  logic        dec_ready
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        run;
    logic        latch;
    logic [5:0]  opcode;
    logic [31:0] dec_signals;
    logic        dec_illegal;

    assign opcode = mem_rdata[31:26];

    // Opcode to operation-signal table. Opcode n (0..17) sets bit 31-n:
    // intd, inte, load, store, add, sub, real_mul, real_clamp, int_real,
    // inc, dec, and, or, xor, asr, asl, call, ret. Anything else is illegal
    // and produces an all-zero vector, so bits [13:0] are never set.
    always_comb begin
        dec_signals = 32'h0000_0000;
        dec_illegal = 1'b0;
        case (opcode)
            6'd0:    dec_signals[31] = 1'b1;
            6'd1:    dec_signals[30] = 1'b1;
            6'd2:    dec_signals[29] = 1'b1;
            6'd3:    dec_signals[28] = 1'b1;
            6'd4:    dec_signals[27] = 1'b1;
            6'd5:    dec_signals[26] = 1'b1;
            6'd6:    dec_signals[25] = 1'b1;
            6'd7:    dec_signals[24] = 1'b1;
            6'd8:    dec_signals[23] = 1'b1;
            6'd9:    dec_signals[22] = 1'b1;
            6'd10:   dec_signals[21] = 1'b1;
            6'd11:   dec_signals[20] = 1'b1;
            6'd12:   dec_signals[19] = 1'b1;
            6'd13:   dec_signals[18] = 1'b1;
            6'd14:   dec_signals[17] = 1'b1;
            6'd15:   dec_signals[16] = 1'b1;
            6'd16:   dec_signals[15] = 1'b1;
            6'd17:   dec_signals[14] = 1'b1;
            default: dec_illegal     = 1'b1;
        endcase
    end

    // Next-state and PC logic. A redirect is honoured everywhere except while
    // a request is outstanding without an ack, because the address must stay
    // stable for memory. A redirect in FETCH restarts the fetch at the new
    // address instead of issuing one at the stale PC. The 'run' flag keeps
    // the first post-reset cycle quiet (mem_req low) before fetching starts.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        latch      = 1'b0;
        case (state)
            S_FETCH: begin
                if (pc_load) begin
                    pc_next = pc_value;
                end else if (run) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    latch      = 1'b1;
                    state_next = S_HOLD;
                    pc_next    = pc_load ? pc_value : pc + PC_STEP;
                end
            end
            S_HOLD: begin
                if (pc_load) begin
                    pc_next = pc_value;
                end
                if (dec_ready) begin
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State, PC and decoded-result registers. An ack seen in the reset cycle
    // is dropped because reset takes precedence over the latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            run     <= 1'b0;
            signals <= 32'h0000_0000;
            operand <= 26'h000_0000;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            run   <= 1'b1;
            if (latch) begin
                signals <= dec_signals;
                operand <= mem_rdata[25:0];
                illegal <= dec_illegal;
            end
        end
    end

    assign mem_addr  = pc;
    assign mem_req   = run && (state != S_HOLD);
    assign dec_valid = (state == S_HOLD);

endmodule

// File: tb/tb_instr_opcode_decoder.sv
// tb_instr_opcode_decoder
//
// Directed bench for instr_opcode_decoder. A second instance built with
// RESET_PC = 32'hFFFF_FFFC shares all inputs and is used for the PC wrap case.
// Expected decodes are pushed to a queue when the memory ack is driven and
// popped when the control-unit side accepts them.

module tb_instr_opcode_decoder;

    typedef struct packed {
        logic [31:0] sig;
        logic [25:0] opd;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        dec_ready;

    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] signals;
    logic [25:0] operand;
    logic        illegal;
    logic        dec_valid;

    logic [31:0] w_mem_addr;
    logic        w_mem_req;
    logic [31:0] w_signals;
    logic [25:0] w_operand;
    logic        w_illegal;
    logic        w_dec_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    dec_t        sb[$];

    always #5 clk = ~clk;

    instr_opcode_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .signals   (signals),
        .operand   (operand),
        .illegal   (illegal),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready)
    );

    instr_opcode_decoder #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (w_mem_addr),
        .mem_req   (w_mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .signals   (w_signals),
        .operand   (w_operand),
        .illegal   (w_illegal),
        .dec_valid (w_dec_valid),
        .dec_ready (dec_ready)
    );

    // Reference decode: opcode n below 18 sets bit 31-n, otherwise illegal.
    function automatic dec_t model(input logic [31:0] word);
        dec_t d;
        int   op;
        op    = int'(word[31:26]);
        d.opd = word[25:0];
        if (op < 18) begin
            d.sig = 32'h1 << (31 - op);
            d.ill = 1'b0;
        end else begin
            d.sig = 32'h0;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one instruction through the memory side. from_fetch says the
    // DUT is sitting in its FETCH cycle; otherwise it is already waiting.
    task automatic applyStimulus(input logic [31:0] word, input int wait_cycles, input bit from_fetch);
        if (from_fetch) begin
            checkOutput("fetch_req", {31'b0, mem_req}, 32'd1);
            checkOutput("fetch_addr", mem_addr, exp_pc);
            tick();
        end
        for (int i = 0; i < wait_cycles; i++) begin
            checkOutput("wait_req", {31'b0, mem_req}, 32'd1);
            checkOutput("wait_addr", mem_addr, exp_pc);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = word;
        sb.push_back(model(word));
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        exp_pc    = exp_pc + 32'd4;
        checkOutput("hold_valid", {31'b0, dec_valid}, 32'd1);
        checkOutput("hold_req", {31'b0, mem_req}, 32'd0);
    endtask

    // Holds off dec_ready for hold_cycles, then accepts the head of the
    // scoreboard, optionally redirecting the PC at the same time.
    task automatic takeDecode(input int hold_cycles, input bit do_load, input logic [31:0] load_val);
        dec_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty_at_take", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        for (int i = 0; i <= hold_cycles; i++) begin
            checkOutput("dec_valid", {31'b0, dec_valid}, 32'd1);
            checkOutput("signals", signals, e.sig);
            checkOutput("operand", {6'b0, operand}, {6'b0, e.opd});
            checkOutput("illegal", {31'b0, illegal}, {31'b0, e.ill});
            checkOutput("hold_req", {31'b0, mem_req}, 32'd0);
            if (i < hold_cycles) tick();
        end
        dec_ready = 1'b1;
        pc_load   = do_load;
        pc_value  = load_val;
        tick();
        void'(sb.pop_front());
        dec_ready = 1'b0;
        pc_load   = 1'b0;
        if (do_load) exp_pc = load_val;
        checkOutput("after_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("after_req", {31'b0, mem_req}, 32'd1);
        checkOutput("after_addr", mem_addr, exp_pc);
        checkOutput("after_signals", signals, e.sig);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] word;

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        pc_load   = 1'b0;
        pc_value  = 32'h0;
        dec_ready = 1'b0;
        exp_pc    = 32'h0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("rst_signals", signals, 32'h0);
        checkOutput("rst_operand", {6'b0, operand}, 32'h0);
        checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_addr_w", w_mem_addr, 32'hFFFF_FFFC);

        // Release, then idle memory
        $display("[TB] reset release and idle memory");
        rst_n = 1'b1;
        tick();
        checkOutput("first_req", {31'b0, mem_req}, 32'd1);
        checkOutput("first_addr", mem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("idle_req", {31'b0, mem_req}, 32'd1);
            checkOutput("idle_addr", mem_addr, 32'h0);
            checkOutput("idle_valid", {31'b0, dec_valid}, 32'd0);
            checkOutput("idle_signals", signals, 32'h0);
        end

        // add, late ack, immediate ready
        $display("[TB] add with late ack");
        applyStimulus(32'h1000_0123, 0, 1'b0);
        checkOutput("add_signals", signals, 32'h0800_0000);
        checkOutput("add_operand", {6'b0, operand}, 32'h0000_0123);
        checkOutput("add_illegal", {31'b0, illegal}, 32'd0);
        takeDecode(0, 1'b0, 32'h0);
        checkOutput("add_next_addr", mem_addr, 32'h4);

        // Opcode sweep including illegal boundaries
        $display("[TB] opcode sweep");
        for (int op = 0; op < 20; op++) begin
            int opc;
            opc  = (op == 19) ? 63 : op;
            word = {opc[5:0], 26'($urandom)};
            applyStimulus(word, op % 3, 1'b1);
            if (opc == 17) checkOutput("ret_signals", signals, 32'h0000_4000);
            if (opc >= 18) begin
                checkOutput("illegal_signals", signals, 32'h0);
                checkOutput("illegal_flag", {31'b0, illegal}, 32'd1);
            end
            checkOutput("onehot", {31'b0, ($countones(signals) <= 1)}, 32'd1);
            takeDecode(0, 1'b0, 32'h0);
        end

        // Backpressure on sub
        $display("[TB] backpressure");
        applyStimulus({6'd5, 26'h2AB_CDEF}, 1, 1'b1);
        checkOutput("sub_signals", signals, 32'h0400_0000);
        takeDecode(5, 1'b0, 32'h0);

        // Redirect in HOLD with ready
        $display("[TB] redirect");
        applyStimulus({6'd16, 26'h000_0100}, 0, 1'b1);
        takeDecode(0, 1'b1, 32'h0000_0100);
        checkOutput("redirect_addr", mem_addr, 32'h0000_0100);

        // Redirect in WAIT without ack is ignored, with ack it wins
        tick();
        pc_load  = 1'b1;
        pc_value = 32'h0000_0200;
        tick();
        checkOutput("wait_load_ignored", mem_addr, 32'h0000_0100);
        pc_value  = 32'h0000_0300;
        mem_ack   = 1'b1;
        mem_rdata = {6'd17, 26'h155_5555};
        sb.push_back(model(mem_rdata));
        tick();
        mem_ack = 1'b0;
        pc_load = 1'b0;
        exp_pc  = 32'h0000_0300;
        checkOutput("wait_ack_load_valid", {31'b0, dec_valid}, 32'd1);
        checkOutput("wait_ack_load_addr", mem_addr, 32'h0000_0300);
        takeDecode(0, 1'b0, 32'h0);

        // PC wrap on the high-reset instance
        $display("[TB] wrap");
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        tick();
        checkOutput("wrap_start", w_mem_addr, 32'hFFFF_FFFC);
        applyStimulus({6'd9, 26'h000_0001}, 0, 1'b1);
        checkOutput("wrap_addr", w_mem_addr, 32'h0000_0000);
        checkOutput("wrap_valid", {31'b0, w_dec_valid}, 32'd1);
        takeDecode(0, 1'b0, 32'h0);

        // Reset during WAIT with ack present
        $display("[TB] mid-fetch reset");
        tick();
        mem_ack   = 1'b1;
        mem_rdata = {6'd2, 26'h3FF_FFFF};
        rst_n     = 1'b0;
        tick();
        mem_ack = 1'b0;
        exp_pc  = 32'h0;
        checkOutput("midrst_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("midrst_req", {31'b0, mem_req}, 32'd0);
        checkOutput("midrst_addr", mem_addr, 32'h0);
        checkOutput("midrst_addr_w", w_mem_addr, 32'hFFFF_FFFC);
        checkOutput("midrst_signals", signals, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_resume_req", {31'b0, mem_req}, 32'd1);
        checkOutput("midrst_resume_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
